// File: rtl/voice_dac_pkg.sv
// Shared types and arithmetic helpers for the voice_dac audio output stage.
// Used by voice_dac (gain FSM, scaler) and voice_dac_sd2 (modulator).
package voice_dac_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } dac_state_t;

    localparam logic [8:0] GAIN_MAX = 9'd256;

    // Full-scale magnitude of a signed sample of the given width.
    function automatic int fs(input int in_w);
        return 32'sd1 <<< (in_w - 32'sd1);
    endfunction

    // a + b clamped to the range of a signed w-bit value.
    function automatic int sat_add(input int a, input int b, input int w);
        int hi;
        int lo;
        int s;
        hi = fs(w) - 32'sd1;
        lo = -fs(w);
        s  = a + b;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/voice_dac_sd2.sv
// Second-order 1-bit sigma-delta modulator for the voice_dac output stage.
// Define VOICE_DAC_DITHER_EN to add LFSR dither at the quantiser input.
module voice_dac_sd2
    import voice_dac_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int ACC_W = IN_W + 4
) (
    input  logic            clk2m5,
    input  logic            res_i,
    input  logic [IN_W-1:0] x,
    output logic            pdm_o
);

    localparam int FS = fs(IN_W);

    logic signed [ACC_W-1:0] i1_r;
    logic signed [ACC_W-1:0] i2_r;
    logic signed [ACC_W-1:0] i1_n;
    logic signed [ACC_W-1:0] i2_n;
    logic                    pdm_r;
    logic                    pdm_n;
    int                      fb_s;
    int                      q_s;

`ifdef VOICE_DAC_DITHER_EN
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_n;

    // Galois LFSR x^16+x^14+x^13+x^11+1, one shift per cycle.
    always_comb begin
        lfsr_n = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
    end

    // Dither state register.
    always_ff @(posedge clk2m5) begin
        if (res_i) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_n;
        end
    end
`endif

    // Both integrators update in one cycle; i2 sees the freshly updated i1.
    always_comb begin
        fb_s = pdm_r ? FS : -FS;
        i1_n = ACC_W'(sat_add(int'(i1_r), int'($signed(x)) - fb_s, ACC_W));
        i2_n = ACC_W'(sat_add(int'(i2_r), int'(i1_n) - fb_s, ACC_W));
`ifdef VOICE_DAC_DITHER_EN
        // Dither only perturbs the decision, never the integrator state.
        q_s  = int'(i2_n) + int'($signed(lfsr_r[1:0]));
`else
        q_s  = int'(i2_n);
`endif
        pdm_n = (q_s >= 32'sd0);
    end

    // Integrator and output registers.
    always_ff @(posedge clk2m5) begin
        if (res_i) begin
            i1_r  <= '0;
            i2_r  <= '0;
            pdm_r <= 1'b0;
        end else begin
            i1_r  <= i1_n;
            i2_r  <= i2_n;
            pdm_r <= pdm_n;
        end
    end

    assign pdm_o = pdm_r;

endmodule

// File: rtl/voice_dac.sv
// Voice audio output: sample capture, pop-free mute/unmute gain ramp and scaler
// feeding a 2nd-order PDM modulator (optional dither via VOICE_DAC_DITHER_EN).
module voice_dac
    import voice_dac_pkg::*;
#(
    parameter int IN_W     = 10,
    parameter int RAMP_DIV = 64,
    parameter int ACC_W    = IN_W + 4
) (
    input  logic            clk2m5,
    input  logic            res_i,
    input  logic [IN_W-1:0] snd_i,
    input  logic            snd_stb_i,
    input  logic            mute_i,
    output logic            pdm_o,
    output logic            active_o,
    output logic [8:0]      gain_o
);

    localparam int              PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam int              PROD_W   = IN_W + 10;

    dac_state_t               state_r;
    dac_state_t               state_n;
    logic [8:0]               gain_r;
    logic [8:0]               gain_n;
    logic [PRE_W-1:0]         pre_r;
    logic [PRE_W-1:0]         pre_n;
    logic                     step_s;
    logic                     active_r;
    logic signed [IN_W-1:0]   sample_q;
    logic signed [IN_W-1:0]   x_r;
    logic signed [PROD_W-1:0] samp_ext_s;
    logic signed [PROD_W-1:0] gain_ext_s;
    logic signed [PROD_W-1:0] prod_s;

    assign step_s = (pre_r == PRE_LAST);

    // Gain FSM next-state: direction changes keep the current gain and prescaler phase.
    always_comb begin
        state_n = state_r;
        gain_n  = gain_r;
        pre_n   = '0;
        case (state_r)
            MUTED: begin
                gain_n = 9'd0;
                if (!mute_i) begin
                    state_n = RAMP_UP;
                end else begin
                    state_n = MUTED;
                end
            end
            RAMP_UP: begin
                pre_n = step_s ? '0 : pre_r + PRE_W'(1);
                if (mute_i) begin
                    state_n = RAMP_DOWN;
                end else if (gain_r >= GAIN_MAX) begin
                    state_n = RUN;
                    gain_n  = GAIN_MAX;
                    pre_n   = '0;
                end else if (step_s) begin
                    gain_n = gain_r + 9'd1;
                    if (gain_r == GAIN_MAX - 9'd1) begin
                        state_n = RUN;
                    end else begin
                        state_n = RAMP_UP;
                    end
                end else begin
                    state_n = RAMP_UP;
                end
            end
            RUN: begin
                gain_n = GAIN_MAX;
                if (mute_i) begin
                    state_n = RAMP_DOWN;
                end else begin
                    state_n = RUN;
                end
            end
            RAMP_DOWN: begin
                pre_n = step_s ? '0 : pre_r + PRE_W'(1);
                if (!mute_i) begin
                    state_n = RAMP_UP;
                end else if (gain_r == 9'd0) begin
                    state_n = MUTED;
                    pre_n   = '0;
                end else if (step_s) begin
                    gain_n = gain_r - 9'd1;
                    if (gain_r == 9'd1) begin
                        state_n = MUTED;
                    end else begin
                        state_n = RAMP_DOWN;
                    end
                end else begin
                    state_n = RAMP_DOWN;
                end
            end
            default: begin
                state_n = MUTED;
                gain_n  = 9'd0;
            end
        endcase
    end

    // Gain FSM state, prescaler and status registers.
    always_ff @(posedge clk2m5) begin
        if (res_i) begin
            state_r  <= MUTED;
            gain_r   <= 9'd0;
            pre_r    <= '0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            gain_r   <= gain_n;
            pre_r    <= pre_n;
            active_r <= (state_n == RUN);
        end
    end

    // Gain is zero-extended so 256 multiplies as +256, not -256.
    assign samp_ext_s = PROD_W'(sample_q);
    assign gain_ext_s = PROD_W'({1'b0, gain_r});
    assign prod_s     = samp_ext_s * gain_ext_s;

    // Sample capture and scaled-sample register.
    always_ff @(posedge clk2m5) begin
        if (res_i) begin
            sample_q <= '0;
            x_r      <= '0;
        end else begin
            if (snd_stb_i) begin
                sample_q <= $signed(snd_i);
            end else begin
                sample_q <= sample_q;
            end
            x_r <= IN_W'(prod_s >>> 4'd8);
        end
    end

    voice_dac_sd2 #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sd2 (
        .clk2m5 (clk2m5),
        .res_i  (res_i),
        .x      (x_r),
        .pdm_o  (pdm_o)
    );

    assign active_o = active_r;
    assign gain_o   = gain_r;

endmodule

// File: doc/voice_dac.md
Name: voice_dac

Overview:
- Audio output stage directly downstream of the voice glue; consumes its signed sample stream (`snd_voice_o`).
- Applies a pop-free mute/unmute gain ramp, then converts the sample to a 1-bit PDM stream with a second-order sigma-delta modulator.
- `pdm_o` drives a PMOD pin through an external RC low-pass.
- Runs on `clk2m5`, the same clock that feeds the voice core.

Parameters:
- IN_W, 10: width of signed input sample; full scale FS = 2^(IN_W-1).
- RAMP_DIV, 64: clk2m5 cycles per gain step (full ramp 256*64 = 16384 cycles, about 6.5 ms).
- ACC_W, IN_W+4: integrator width.

Ports:
- clk2m5  in  1  system clock, 2.5 MHz.
- res_i  in  1  reset, synchronous, active-high.
- snd_i  in  IN_W  signed two's-complement sample from voice glue.
- snd_stb_i  in  1  one-cycle strobe; snd_i valid this cycle.
- mute_i  in  1  level; 1 requests silence.
- pdm_o  out  1  registered PDM output.
- active_o  out  1  1 only in RUN state.
- gain_o  out  9  current gain, 0..256.

Behaviour:
- Clocking and reset: single clock clk2m5; reset res_i is synchronous, active-high. On reset:
  - state=MUTED, gain=0, sample_q=0, integrators=0;
  - pdm_o=0, active_o=0, gain_o=0;
  - LFSR=16'hACE1 (when the optional feature is compiled in).
- Capture:
  - snd_stb_i=1 loads sample_q<=snd_i; otherwise sample_q holds.
  - Capture happens in every state, including MUTED.
- Scaling:
  - prod = sample_q * gain, a signed (IN_W+10)-bit product with gain zero-extended.
  - x = prod >>> 8 (arithmetic shift), giving an IN_W-bit value; gain=256 reproduces sample_q exactly.
  - x is registered; 1 cycle after capture.
- Gain FSM (enum MUTED, RAMP_UP, RUN, RAMP_DOWN):
  - Prescaler counts 0..RAMP_DIV-1, free-running during the RAMP states and cleared in MUTED/RUN; a step occurs on wrap.
  - MUTED: gain=0. Go to RAMP_UP when mute_i=0.
  - RAMP_UP: gain+1 per step. Go to RUN on the step that makes gain=256.
  - RUN: gain=256. Go to RAMP_DOWN when mute_i=1.
  - RAMP_DOWN: gain-1 per step. Go to MUTED on the step that makes gain=0.
  - mute_i=1 during RAMP_UP: go to RAMP_DOWN next cycle, continuing from the current gain with no jump.
  - mute_i=0 during RAMP_DOWN: go to RAMP_UP likewise.
  - Gain never leaves 0..256.
- Modulator (each cycle):
  - fb = +FS if pdm_o=1, else -FS.
  - i1 <= sat(i1 + x - fb).
  - i2 <= sat(i2 + i1 - fb), using the new i1.
  - pdm_o <= (q >= 0), where q = i2 (plus dither when enabled).
  - sat clamps to signed ACC_W limits.
- Silence: x=0 yields a 50 % duty pattern, so MUTED is DC-centred and silent.
- Latency: snd_stb_i to first influence on pdm_o is 3 cycles (capture, scale, integrate/quantise).
- Reset mid-operation: any state returns to MUTED at gain=0 on the next edge. No ramp-down is performed; this is the only permitted click.
- Strobe during a gain step: both take effect; the step uses the new sample from the next cycle.

Optional Feature:
- Macro: VOICE_DAC_DITHER_EN.
- When defined:
  - 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1, advancing every cycle.
  - Quantiser input q = i2 + sext(lfsr[1:0]), where lfsr[1:0] is treated as signed 2-bit (-2..+1).
  - The integrator state itself is not modified.
- When undefined: q = i2, with no LFSR logic.

Decomposition:
- Package voice_dac_pkg:
  - dac_state_t enum;
  - GAIN_MAX=256;
  - function fs(IN_W);
  - saturating-add function.
- Sub-module voice_dac_sd2: second-order modulator.
  - Inputs: x, clk2m5, res_i.
  - Output: pdm_o.
  - The dither LFSR lives inside it.
- Top-level voice_dac holds capture, gain FSM and scaler.

Test Plan:
- Reset, mute_i=0, snd_i=0 strobed once:
  - gain_o=256 and active_o=1 exactly 16384±1 cycles after the RAMP_UP entry;
  - over 1024 cycles in RUN, the ones count is 512±2.
- RUN, strobe snd_i=+256 (FS=512): after 64 settle cycles, ones in 1024 cycles = 768±4.
- RUN, strobe snd_i=-384: ones in 1024 cycles = 128±4.
- mute_i=1 while in RAMP_UP at gain_o=100:
  - next step shows gain_o=99 in RAMP_DOWN;
  - reaches MUTED with gain_o=0 after 99 further steps.
- res_i=1 for one cycle during RUN:
  - next cycle gain_o=0, active_o=0, pdm_o=0, state MUTED;
  - with mute_i=0, the ramp restarts on the following cycle.
- With VOICE_DAC_DITHER_EN, snd_i=0 in RUN:
  - ones in 4096 cycles = 2048±16;
  - pdm_o sequence is not strictly periodic with period 2 (detects dither active).
